// File: rtl/ifu_fetch.sv
// IF-stage fetch unit: PC generation, single-outstanding instruction bus reads,
// one-entry output buffer toward IF/ID and branch/trap redirect handling.
module ifu_fetch #(
    parameter int            AW       = 32,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_stall,
    input  logic          branch_take,
    input  logic [AW-1:0] branch_target,
    input  logic          trap_take,
    input  logic [AW-1:0] trap_target,
    output logic          ibus_read,
    output logic [AW-1:0] ibus_address,
    input  logic          ibus_waitrequest,
    input  logic [31:0]   ibus_readdata,
    input  logic          ibus_readdatavalid,
    output logic          if_valid,
    output logic [31:0]   if_instr,
    output logic [AW-1:0] if_pc,
    output logic          fetch_busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RSP
    } state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_t        r_state;
    state_t        w_state_n;
    logic [AW-1:0] r_pc;
    logic [AW-1:0] r_addr;
    logic          r_held;
    logic          r_drop;
    logic          r_valid;
    logic [31:0]   r_instr;
    logic [AW-1:0] r_if_pc;

    logic          w_redir;
    logic [AW-1:0] w_target;
    logic          w_read;
    logic [AW-1:0] w_addr;
    logic          w_accept;
    logic          w_rsp;
    logic          w_deliver;

    assign w_redir   = trap_take | branch_take;
    assign w_target  = trap_take ? trap_target : branch_target;
    // A read already on the bus stays up until accepted, even under stall.
    assign w_read    = (r_state == S_REQ) & (r_held | ~(r_valid & if_stall));
    assign w_addr    = r_held ? r_addr : r_pc;
    assign w_accept  = w_read & ~ibus_waitrequest;
    assign w_rsp     = (r_state == S_RSP) & ibus_readdatavalid;
    assign w_deliver = w_rsp & ~r_drop & ~w_redir;

    always_comb begin
        w_state_n = r_state;
        unique case (r_state)
            S_IDLE: w_state_n = S_REQ;
            S_REQ:  if (w_accept) w_state_n = S_RSP;
            S_RSP:  if (ibus_readdatavalid) w_state_n = S_REQ;
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc   <= RESET_PC;
            r_addr <= RESET_PC;
            r_held <= 1'b0;
            r_drop <= 1'b0;
        end else begin
            r_addr <= w_addr;
            r_held <= w_read & ibus_waitrequest;
            if (w_redir)        r_pc <= w_target;
            else if (w_deliver) r_pc <= r_pc + AW'(4);
            // A read in flight at redirect time returns stale data.
            if (w_rsp)
                r_drop <= 1'b0;
            else if (w_redir & ((r_state == S_RSP) | w_read))
                r_drop <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_instr <= NOP;
            r_if_pc <= RESET_PC;
        end else if (w_redir) begin
            r_valid <= 1'b0;
        end else if (w_deliver) begin
            r_valid <= 1'b1;
            r_instr <= ibus_readdata;
            r_if_pc <= r_pc;
        end else if (r_valid & ~if_stall) begin
            r_valid <= 1'b0;
        end
    end

    assign ibus_read    = w_read;
    assign ibus_address = w_addr;
    assign if_valid     = r_valid;
    assign if_instr     = r_instr;
    assign if_pc        = r_if_pc;
    assign fetch_busy   = ~r_valid;

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomized bench for ifu_fetch: bus slave model plus a program-order
// reference (next expected PC) with directed redirect/wrap/reset cases.
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_stall;
    logic        branch_take;
    logic [31:0] branch_target;
    logic        trap_take;
    logic [31:0] trap_target;
    logic        ibus_read;
    logic [31:0] ibus_address;
    logic        ibus_waitrequest;
    logic [31:0] ibus_readdata;
    logic        ibus_readdatavalid;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        fetch_busy;

    always #5 clk = ~clk;

    ifu_fetch #(.AW(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .if_stall(if_stall),
        .branch_take(branch_take), .branch_target(branch_target),
        .trap_take(trap_take), .trap_target(trap_target),
        .ibus_read(ibus_read), .ibus_address(ibus_address),
        .ibus_waitrequest(ibus_waitrequest),
        .ibus_readdata(ibus_readdata),
        .ibus_readdatavalid(ibus_readdatavalid),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .fetch_busy(fetch_busy)
    );

    int errs = 0;
    int checks = 0;

    // knobs
    int force_wait = -1;
    int lat_fix    = -1;
    int stall_pct  = 0;
    int redir_pct  = 0;
    int spur_en    = 0;
    logic        d_go = 0, d_trap = 0, d_branch = 0;
    logic [31:0] d_tt = 0, d_bt = 0;

    // model / snapshot state
    logic [31:0] exp_pc;
    logic        s_read, s_wait, s_valid, s_stall, s_redir;
    logic [31:0] s_addr, s_tgt, s_pc, s_instr;
    logic        sl_busy;
    int          sl_cnt;
    logic [31:0] sl_addr;
    logic [31:0] acc_q[$];
    logic [31:0] dlv_q[$];

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_model();
        exp_pc = 32'h0;
        {s_read, s_wait, s_valid, s_stall, s_redir} = '0;
        s_addr = 0; s_tgt = 0; s_pc = 0; s_instr = 0;
        sl_busy = 0; sl_cnt = 0; sl_addr = 0;
    endtask

    task automatic drive_idle();
        if_stall = 0; branch_take = 0; trap_take = 0;
        branch_target = 0; trap_target = 0;
        ibus_waitrequest = 0; ibus_readdatavalid = 0; ibus_readdata = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_idle();
        clear_model();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_read", ibus_read, 0);
        chk("rst_addr", ibus_address, 32'h0);
        chk("rst_valid", if_valid, 0);
        chk("rst_busy", fetch_busy, 1);
        chk("rst_instr", if_instr, 32'h13);
        chk("rst_pc", if_pc, 32'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic step();
        logic [31:0] t;
        logic        p_held;
        @(negedge clk);
        // check what happened at the last edge
        chk("busy", fetch_busy, {31'b0, ~if_valid});
        if (s_read & s_wait) begin
            chk("hold_rd", ibus_read, 1);
            chk("hold_addr", ibus_address, s_addr);
        end
        if (s_redir) begin
            chk("redir_clr", if_valid, 0);
            exp_pc = s_tgt;
        end else if (s_valid & s_stall) begin
            chk("stall_v", if_valid, 1);
            chk("stall_pc", if_pc, s_pc);
            chk("stall_in", if_instr, s_instr);
        end else if (if_valid) begin
            chk("pc", if_pc, exp_pc);
            chk("instr", if_instr, mem(exp_pc));
            dlv_q.push_back(if_pc);
            exp_pc = exp_pc + 32'd4;
        end
        // slave response
        ibus_readdatavalid = 0;
        ibus_readdata = $urandom;
        if (sl_busy) begin
            if (sl_cnt == 0) begin
                ibus_readdatavalid = 1;
                ibus_readdata = mem(sl_addr);
                sl_busy = 0;
            end else sl_cnt--;
        end else if (spur_en != 0 && $urandom_range(15) == 0) begin
            ibus_readdatavalid = 1;
        end
        ibus_waitrequest = (force_wait >= 0) ? force_wait[0]
                                             : ($urandom_range(3) == 0);
        if_stall = ($urandom_range(99) < stall_pct);
        if (d_go) begin
            trap_take = d_trap; branch_take = d_branch;
            trap_target = d_tt; branch_target = d_bt;
        end else begin
            trap_take = 0; branch_take = 0;
            if ($urandom_range(99) < redir_pct) begin
                trap_take = $urandom_range(1);
                branch_take = ~trap_take | $urandom_range(1);
            end
            t = $urandom; t[1:0] = 2'b00; trap_target = t;
            t = $urandom; t[1:0] = 2'b00; branch_target = t;
        end
        #1;
        p_held = s_read & s_wait;
        if (if_valid & if_stall & ~p_held)
            chk("no_issue", ibus_read, 0);
        s_read  = ibus_read;
        s_wait  = ibus_waitrequest;
        s_addr  = ibus_address;
        s_valid = if_valid;
        s_stall = if_stall;
        s_redir = trap_take | branch_take;
        s_tgt   = trap_take ? trap_target : branch_target;
        s_pc    = if_pc;
        s_instr = if_instr;
        if (ibus_read & ~ibus_waitrequest) begin
            chk("one_outst", sl_busy, 0);
            sl_busy = 1;
            sl_addr = ibus_address;
            sl_cnt  = (lat_fix >= 0) ? lat_fix : $urandom_range(3);
            acc_q.push_back(ibus_address);
        end
    endtask

    task automatic wait_dlv(input int n, input string name);
        int base;
        base = dlv_q.size();
        for (int i = 0; i < 60 && dlv_q.size() < base + n; i++) step();
        if (dlv_q.size() < base + n) begin
            errs++; checks++;
            $display("FAIL %s: timeout got %0d deliveries expected %0d",
                     name, dlv_q.size() - base, n);
        end
    endtask

    task automatic wait_acc(input string name);
        int base;
        base = acc_q.size();
        for (int i = 0; i < 60 && acc_q.size() == base; i++) step();
        if (acc_q.size() == base) begin
            errs++; checks++;
            $display("FAIL %s: timeout no accepted read", name);
        end
    endtask

    initial begin
        int n0;
        do_reset();
        // zero-wait, 1-cycle latency streaming
        force_wait = 0; lat_fix = 0;
        repeat (10) step();
        chk("acc0", acc_q.size() > 2 ? acc_q[0] : 32'hDEAD, 32'h0);
        chk("acc1", acc_q.size() > 2 ? acc_q[1] : 32'hDEAD, 32'h4);
        chk("acc2", acc_q.size() > 2 ? acc_q[2] : 32'hDEAD, 32'h8);
        chk("dlv0", dlv_q.size() > 1 ? dlv_q[0] : 32'hDEAD, 32'h0);
        chk("dlv1", dlv_q.size() > 1 ? dlv_q[1] : 32'hDEAD, 32'h4);
        // waitrequest held, then stall
        force_wait = 1;
        repeat (5) step();
        force_wait = 0;
        wait_dlv(1, "after_wait");
        stall_pct = 100;
        repeat (4) step();
        stall_pct = 0;
        repeat (6) step();
        // branch while waiting for a response
        lat_fix = 3;
        wait_acc("br_acc");
        d_go = 1; d_branch = 1; d_trap = 0; d_bt = 32'h100; d_tt = 32'h0;
        step();
        d_go = 0;
        wait_dlv(1, "br_dlv");
        chk("br_target", dlv_q[$], 32'h100);
        // trap beats branch during a held read
        lat_fix = 0; force_wait = 1;
        for (int i = 0; i < 20 && !s_read; i++) step();
        chk("held_seen", s_read, 1);
        d_go = 1; d_branch = 1; d_trap = 1; d_bt = 32'h200; d_tt = 32'h80;
        step();
        d_go = 0;
        repeat (2) step();
        force_wait = 0;
        wait_dlv(1, "trap_dlv");
        chk("trap_target", dlv_q[$], 32'h80);
        // PC wraps past the top of the address space
        d_go = 1; d_branch = 1; d_trap = 0; d_bt = 32'hFFFF_FFFC;
        step();
        d_go = 0;
        wait_dlv(2, "wrap_dlv");
        chk("wrap_a", dlv_q[$-1], 32'hFFFF_FFFC);
        chk("wrap_b", dlv_q[$], 32'h0);
        // async reset while waiting on a response
        lat_fix = 3;
        wait_acc("rst_acc");
        step();
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", if_valid, 0);
        chk("arst_busy", fetch_busy, 1);
        chk("arst_read", ibus_read, 0);
        chk("arst_addr", ibus_address, 32'h0);
        chk("arst_pc", if_pc, 32'h0);
        chk("arst_instr", if_instr, 32'h13);
        do_reset();
        // randomized traffic
        force_wait = -1; lat_fix = -1;
        stall_pct = 30; redir_pct = 5; spur_en = 1;
        n0 = dlv_q.size();
        repeat (3000) step();
        chk("progress", (dlv_q.size() - n0) > 100, 1);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
